// File: rtl/bram_coef_streamer.sv
// BRAM port-B reader that unpacks wide words into a valid/ready coefficient stream.
// Define COEF_REDUCE_EN to subtract q=3329 once from every lane value >= q.
module bram_coef_streamer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 128,
  parameter int COEF_W = 16,
  parameter int LANES  = 8
) (
  input  logic                s_axi_aclk_0,
  input  logic                s_axi_aresetn_0,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     num_words,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   addrb_0,
  output logic                enb_0,
  output logic [DATA_W/8-1:0] web_0,
  output logic [DATA_W-1:0]   dinb_0,
  input  logic [DATA_W-1:0]   doutb_0,
  output logic [COEF_W-1:0]   m_coef_tdata,
  output logic                m_coef_tvalid,
  input  logic                m_coef_tready,
  output logic                m_coef_tlast
);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} state_e;

  logic clk, rst_n;
  assign clk   = s_axi_aclk_0;
  assign rst_n = s_axi_aresetn_0;

  // Control: FSM, read issue and status outputs
  state_e             state_q;
  logic               busy_q, done_q, enb_q;
  logic [ADDR_W-1:0]  addr_q, base_q;
  logic [CNT_W-1:0]   num_q, iss_q;

  // Datapath: read return tracking, word register W, prefetch register N, output register
  logic               ret_q, ret_d;
  logic [CNT_W-1:0]   ret_cnt_q, ret_cnt_d;
  logic [DATA_W-1:0]  w_q, w_d, n_q, n_d;
  logic               w_vld_q, w_vld_d, w_last_q, w_last_d;
  logic               n_vld_q, n_vld_d, n_last_q, n_last_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [COEF_W-1:0]  tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d, tlast_q, tlast_d;

  logic beat, w_drain, ret_last, can_issue;

  assign beat      = tvalid_q & m_coef_tready;
  assign w_drain   = beat && (lane_q == LAST_LANE);
  assign ret_last  = (ret_cnt_q == num_q - CNT_W'(1));
  // One read in flight covers both the enable cycle and the data-return cycle.
  assign can_issue = (iss_q < num_q) && !enb_q && !ret_q && !n_vld_q;

  function automatic logic [COEF_W-1:0] lane_fn(input logic [COEF_W-1:0] v);
`ifdef COEF_REDUCE_EN
    return (v >= COEF_W'(3329)) ? v - COEF_W'(3329) : v;
`else
    return v;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      enb_q   <= 1'b0;
      addr_q  <= '0;
      base_q  <= '0;
      num_q   <= '0;
      iss_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register sees pre-edge values of the others.
      done_q <= 1'b0;
      enb_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              base_q  <= base_addr;
              num_q   <= num_words;
              enb_q   <= 1'b1;
              addr_q  <= base_addr;
              iss_q   <= CNT_W'(1);
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (can_issue) begin
            enb_q  <= 1'b1;
            addr_q <= base_q + iss_q[ADDR_W-1:0];
            iss_q  <= iss_q + CNT_W'(1);
          end
          if (beat && tlast_q) begin
            state_q <= ST_FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    ret_d     = enb_q;
    ret_cnt_d = ret_cnt_q;
    w_d       = w_q;
    w_vld_d   = w_vld_q;
    w_last_d  = w_last_q;
    n_d       = n_q;
    n_vld_d   = n_vld_q;
    n_last_d  = n_last_q;
    lane_d    = lane_q;

    if (beat) lane_d = lane_q + LANE_W'(1);

    if (w_drain) begin
      w_vld_d = 1'b0;
      if (n_vld_q) begin
        w_d      = n_q;
        w_last_d = n_last_q;
        w_vld_d  = 1'b1;
        n_vld_d  = 1'b0;
      end
    end

    if (ret_q) begin
      ret_cnt_d = ret_cnt_q + CNT_W'(1);
      if (!w_vld_q || w_drain) begin
        w_d      = doutb_0;
        w_vld_d  = 1'b1;
        w_last_d = ret_last;
      end else begin
        n_d      = doutb_0;
        n_vld_d  = 1'b1;
        n_last_d = ret_last;
      end
    end

    if (state_q == ST_IDLE) ret_cnt_d = '0;

    // The output register always mirrors the next lane of W, so it is stable during stalls.
    tdata_d  = lane_fn(w_d[lane_d*COEF_W +: COEF_W]);
    tvalid_d = w_vld_d;
    tlast_d  = w_vld_d && w_last_d && (lane_d == LAST_LANE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q     <= 1'b0;
      ret_cnt_q <= '0;
      w_q       <= '0;
      w_vld_q   <= 1'b0;
      w_last_q  <= 1'b0;
      n_q       <= '0;
      n_vld_q   <= 1'b0;
      n_last_q  <= 1'b0;
      lane_q    <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
    end else begin
      ret_q     <= ret_d;
      ret_cnt_q <= ret_cnt_d;
      w_q       <= w_d;
      w_vld_q   <= w_vld_d;
      w_last_q  <= w_last_d;
      n_q       <= n_d;
      n_vld_q   <= n_vld_d;
      n_last_q  <= n_last_d;
      lane_q    <= lane_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign enb_0         = enb_q;
  assign addrb_0       = addr_q;
  assign web_0         = '0;
  assign dinb_0        = '0;
  assign m_coef_tdata  = tdata_q;
  assign m_coef_tvalid = tvalid_q;
  assign m_coef_tlast  = tlast_q;

endmodule

// File: tb/tb_bram_coef_streamer.sv
// Directed bench for bram_coef_streamer with a 1-cycle-latency BRAM model.
module tb_bram_coef_streamer;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    base_addr;
  logic [8:0]    num_words;
  logic          busy, done, enb_0, m_coef_tvalid, m_coef_tready, m_coef_tlast;
  logic [7:0]    addrb_0;
  logic [15:0]   web_0;
  logic [127:0]  dinb_0, doutb_0;
  logic [15:0]   m_coef_tdata;

  logic [127:0]  mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (enb_0) doutb_0 <= mem[addrb_0];

  bram_coef_streamer dut (
    .s_axi_aclk_0    (clk),
    .s_axi_aresetn_0 (rst_n),
    .start           (start),
    .base_addr       (base_addr),
    .num_words       (num_words),
    .busy            (busy),
    .done            (done),
    .addrb_0         (addrb_0),
    .enb_0           (enb_0),
    .web_0           (web_0),
    .dinb_0          (dinb_0),
    .doutb_0         (doutb_0),
    .m_coef_tdata    (m_coef_tdata),
    .m_coef_tvalid   (m_coef_tvalid),
    .m_coef_tready   (m_coef_tready),
    .m_coef_tlast    (m_coef_tlast)
  );

  typedef struct {
    int beats, enbs, first_valid, last_valid, done_cyc, dones, tlasts;
    int data_bad, last_bad, addr_bad, flight_bad, stall_bad, const_bad, busy_bad;
    bit busy1, rst_drop, timeout;
    logic [15:0] first_data, last_data;
    logic [7:0][15:0] first8;
  } run_res_t;

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  num;
    bit          rnd;
    int          exp_beats, exp_enbs, exp_first_valid, exp_done_cyc;
    logic [15:0] exp_first, exp_last;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] red(input logic [15:0] v);
`ifdef COEF_REDUCE_EN
    return (v >= 16'd3329) ? v - 16'd3329 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [15:0] ref_coef(input logic [7:0] b, input int k);
    logic [127:0] w;
    w = mem[8'(int'(b) + k / 8)];
    return red(w[(k % 8) * 16 +: 16]);
  endfunction

  task automatic run_stream(input logic [7:0] b, input logic [8:0] n, input bit rnd,
                            input int spur_cyc, input int rst_beat, output run_res_t r);
    int cyc, tail, last_enb;
    bit hold_v;
    logic [15:0] hold_d;
    logic hold_l;
    r = '{default: 0};
    r.first_valid = -1;
    cyc = 0; tail = -1; last_enb = -10; hold_v = 1'b0; hold_d = '0; hold_l = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = b; num_words = n;
    m_coef_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = (cyc == spur_cyc);
      if (cyc == spur_cyc) begin base_addr = 8'h40; num_words = 9'd1; end
      m_coef_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == 1) r.busy1 = busy;
      if (web_0 != '0 || dinb_0 != '0) r.const_bad++;
      if (hold_v && (!m_coef_tvalid || m_coef_tdata != hold_d || m_coef_tlast != hold_l))
        r.stall_bad++;
      hold_v = m_coef_tvalid && !m_coef_tready;
      hold_d = m_coef_tdata;
      hold_l = m_coef_tlast;
      if (enb_0) begin
        if (cyc - last_enb < 2) r.flight_bad++;
        if (addrb_0 != 8'(int'(b) + r.enbs)) r.addr_bad++;
        last_enb = cyc;
        r.enbs++;
      end
      if (m_coef_tvalid) begin
        if (r.first_valid < 0) r.first_valid = cyc;
        r.last_valid = cyc;
      end
      if (m_coef_tvalid && m_coef_tready) begin
        if (m_coef_tdata != ref_coef(b, r.beats)) r.data_bad++;
        if (m_coef_tlast != (r.beats == 8 * int'(n) - 1)) r.last_bad++;
        if (r.beats == 0) r.first_data = m_coef_tdata;
        if (r.beats < 8) r.first8[r.beats] = m_coef_tdata;
        r.last_data = m_coef_tdata;
        if (m_coef_tlast) r.tlasts++;
        r.beats++;
        if (rst_beat >= 0 && r.beats == rst_beat) begin
          rst_n = 1'b0;
          #1;
          r.rst_drop = !m_coef_tvalid && !enb_0 && !busy;
          repeat (2) @(negedge clk);
          rst_n = 1'b1;
          tail = cyc + 12;
        end
      end
      if (done) begin
        r.dones++;
        r.done_cyc = cyc;
        if (busy) r.busy_bad++;
        if (tail < 0) tail = cyc + 6;
      end
      if (tail >= 0 && cyc >= tail) break;
      if (cyc >= 4000) begin r.timeout = 1'b1; break; end
    end
    start = 1'b0;
  endtask

  vec_t     vecs [5];
  run_res_t r;
  logic [15:0] exp_red [8];

  initial begin
    start = 1'b0; base_addr = '0; num_words = '0; m_coef_tready = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 256; i++)
      for (int l = 0; l < 8; l++)
        mem[i][l*16 +: 16] = {8'(i), 8'(l * 17 + 3)};
    mem[8'h0F] = 128'hCAFEBABE_DEADBEEF_12345678_90ABCDEF;
    mem[8'h80] = {16'h0001, 16'h0D02, 16'hFFFF, 16'h0CFF, 16'h0000, 16'h1A02, 16'h0D00, 16'h0D01};

    //              base   num    rnd  beats enbs fv  done first     last
    vecs[0] = '{8'h0F, 9'd1,  1'b0, 8,   1,   3,  11,  16'hCDEF, 16'hCAFE};
    vecs[1] = '{8'h00, 9'd32, 1'b0, 256, 32,  3,  259, 16'h0003, 16'h1F7A};
    vecs[2] = '{8'h00, 9'd32, 1'b1, 256, 32,  3,  0,   16'h0003, 16'h1F7A};
    vecs[3] = '{8'hFE, 9'd4,  1'b0, 32,  4,   3,  35,  16'hFE03, 16'h017A};
    vecs[4] = '{8'h10, 9'd0,  1'b0, 0,   0,   0,  1,   16'h0000, 16'h0000};

    repeat (3) @(negedge clk);
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_enb",    enb_0, 0);
    check("rst_tvalid", m_coef_tvalid, 0);
    check("rst_tlast",  m_coef_tlast, 0);
    check("rst_addr",   addrb_0, 0);
    check("rst_tdata",  m_coef_tdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_stream(vecs[i].base, vecs[i].num, vecs[i].rnd, -1, -1, r);
      check($sformatf("v%0d_timeout", i), r.timeout, 0);
      check($sformatf("v%0d_beats", i), r.beats, vecs[i].exp_beats);
      check($sformatf("v%0d_enbs", i), r.enbs, vecs[i].exp_enbs);
      check($sformatf("v%0d_dones", i), r.dones, 1);
      check($sformatf("v%0d_tlasts", i), r.tlasts, (vecs[i].exp_beats != 0) ? 1 : 0);
      check($sformatf("v%0d_busy1", i), r.busy1, (vecs[i].exp_beats != 0) ? 1 : 0);
      check($sformatf("v%0d_busy_at_done", i), r.busy_bad, 0);
      check($sformatf("v%0d_data", i), r.data_bad, 0);
      check($sformatf("v%0d_tlast_pos", i), r.last_bad, 0);
      check($sformatf("v%0d_addr_seq", i), r.addr_bad, 0);
      check($sformatf("v%0d_inflight", i), r.flight_bad, 0);
      check($sformatf("v%0d_stall_hold", i), r.stall_bad, 0);
      check($sformatf("v%0d_web_dinb", i), r.const_bad, 0);
      if (vecs[i].exp_done_cyc != 0)
        check($sformatf("v%0d_done_cyc", i), r.done_cyc, vecs[i].exp_done_cyc);
      if (vecs[i].exp_beats != 0) begin
        check($sformatf("v%0d_first_valid", i), r.first_valid, vecs[i].exp_first_valid);
        check($sformatf("v%0d_first_data", i), r.first_data, red(vecs[i].exp_first));
        check($sformatf("v%0d_last_data", i), r.last_data, red(vecs[i].exp_last));
        if (!vecs[i].rnd)
          check($sformatf("v%0d_gapless", i), r.last_valid - r.first_valid + 1, vecs[i].exp_beats);
      end
    end

    run_stream(8'h00, 9'd4, 1'b0, 5, -1, r);
    check("spur_timeout", r.timeout, 0);
    check("spur_beats", r.beats, 32);
    check("spur_enbs", r.enbs, 4);
    check("spur_addr_seq", r.addr_bad, 0);
    check("spur_data", r.data_bad, 0);
    check("spur_dones", r.dones, 1);

    run_stream(8'h00, 9'd32, 1'b0, -1, 100, r);
    check("abort_timeout", r.timeout, 0);
    check("abort_drop", r.rst_drop, 1);
    check("abort_beats", r.beats, 100);
    check("abort_no_done", r.dones, 0);
    check("abort_data", r.data_bad, 0);

`ifdef COEF_REDUCE_EN
    exp_red = '{16'h0000, 16'h0D00, 16'h0D01, 16'h0000, 16'h0CFF, 16'hF2FE, 16'h0001, 16'h0001};
`else
    exp_red = '{16'h0D01, 16'h0D00, 16'h1A02, 16'h0000, 16'h0CFF, 16'hFFFF, 16'h0D02, 16'h0001};
`endif
    run_stream(8'h80, 9'd1, 1'b0, -1, -1, r);
    check("lanes_timeout", r.timeout, 0);
    check("lanes_beats", r.beats, 8);
    check("lanes_done_cyc", r.done_cyc, 11);
    for (int k = 0; k < 8; k++)
      check($sformatf("lanes_beat%0d", k), r.first8[k], exp_red[k]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
